// File: rtl/decode_stage_pkg.sv
// Shared Y86-64 decode definitions: datapath width, instruction codes,
// register IDs, status codes and the F/D pipeline register layout.
package decode_stage_pkg;

    localparam int DATA_WID = 64;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register IDs
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_t;

    typedef struct packed {
        logic [3:0]          icode;
        logic [3:0]          ifun;
        logic [3:0]          ra;
        logic [3:0]          rb;
        logic [DATA_WID-1:0] valc;
        logic [DATA_WID-1:0] valp;
        stat_t               stat;
    } fd_t;

    // Contents of the F/D register after reset or a bubble: a harmless NOP
    localparam fd_t FD_BUBBLE = '{
        icode: I_NOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valc:  '0,
        valp:  '0,
        stat:  STAT_AOK
    };

    // Memory errors dominate, then illegal instructions, then halt
    function automatic stat_t fetch_stat(input logic imem_error,
                                         input logic instr_valid,
                                         input logic [3:0] icode);
        if (imem_error)
            return STAT_ADR;
        else if (!instr_valid)
            return STAT_INS;
        else if (icode == I_HALT)
            return STAT_HLT;
        else
            return STAT_AOK;
    endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Architectural register file: 15 entries, two write ports (M port wins on
// a shared destination), two combinational read ports with write-first bypass.
module reg_file
    import decode_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          src_a,
    input  logic [3:0]          src_b,
    input  logic [3:0]          dst_e,
    input  logic [3:0]          dst_m,
    input  logic [DATA_WID-1:0] val_e,
    input  logic [DATA_WID-1:0] val_m,
    output logic [DATA_WID-1:0] val_a,
    output logic [DATA_WID-1:0] val_b
);

    logic [DATA_WID-1:0] regs [0:14];
    logic [3:0]          src_sel [0:1];
    logic [DATA_WID-1:0] rd_val  [0:1];

    assign src_sel[0] = src_a;
    assign src_sel[1] = src_b;
    assign val_a      = rd_val[0];
    assign val_b      = rd_val[1];

    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_entry
            // Per-entry write: M data overrides E data when both target this entry
            always_ff @(posedge clk) begin
                if (rst)
                    regs[gi] <= '0;
                else if (dst_m == 4'(gi))
                    regs[gi] <= val_m;
                else if (dst_e == 4'(gi))
                    regs[gi] <= val_e;
            end
        end

        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            // Read with bypass so a value written this cycle is seen immediately
            always_comb begin
                rd_val[gi] = '0;
                if (src_sel[gi] == RNONE)
                    rd_val[gi] = '0;
                else if (src_sel[gi] == dst_m)
                    rd_val[gi] = val_m;
                else if (src_sel[gi] == dst_e)
                    rd_val[gi] = val_e;
                else
                    rd_val[gi] = regs[src_sel[gi]];
            end
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: F/D pipeline register, source/destination register
// selection, register file read and valA selection.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          f_icode,
    input  logic [3:0]          f_ifun,
    input  logic [3:0]          f_rA,
    input  logic [3:0]          f_rB,
    input  logic [DATA_WID-1:0] f_valC,
    input  logic [DATA_WID-1:0] f_valP,
    input  logic                f_instr_valid,
    input  logic                f_imem_error,
    input  logic                D_stall,
    input  logic                D_bubble,
    input  logic [3:0]          W_dstE,
    input  logic [3:0]          W_dstM,
    input  logic [DATA_WID-1:0] W_valE,
    input  logic [DATA_WID-1:0] W_valM,
    output logic [3:0]          d_icode,
    output logic [3:0]          d_ifun,
    output logic [DATA_WID-1:0] d_valC,
    output logic [DATA_WID-1:0] d_valA,
    output logic [DATA_WID-1:0] d_valB,
    output logic [3:0]          d_srcA,
    output logic [3:0]          d_srcB,
    output logic [3:0]          d_dstE,
    output logic [3:0]          d_dstM,
    output logic [2:0]          d_stat
);

    fd_t                 fd_reg;
    fd_t                 fd_next;
    logic [DATA_WID-1:0] rf_val_a;
    logic [DATA_WID-1:0] rf_val_b;

    // F/D next contents: stall holds, bubble injects a NOP, otherwise load fetch
    always_comb begin
        fd_next = fd_reg;
        if (D_stall) begin
            fd_next = fd_reg;
        end else if (D_bubble) begin
            fd_next = FD_BUBBLE;
        end else begin
            fd_next.icode = f_icode;
            fd_next.ifun  = f_ifun;
            fd_next.ra    = f_rA;
            fd_next.rb    = f_rB;
            fd_next.valc  = f_valC;
            fd_next.valp  = f_valP;
            fd_next.stat  = fetch_stat(f_imem_error, f_instr_valid, f_icode);
        end
    end

    // F/D pipeline register; reset overrides stall
    always_ff @(posedge clk) begin
        if (rst)
            fd_reg <= FD_BUBBLE;
        else
            fd_reg <= fd_next;
    end

    // Register ID selection from the latched instruction code
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (fd_reg.icode)
            I_RRMOVQ: begin
                d_srcA = fd_reg.ra;
                d_dstE = fd_reg.rb;
            end
            I_IRMOVQ: d_dstE = fd_reg.rb;
            I_RMMOVQ: begin
                d_srcA = fd_reg.ra;
                d_srcB = fd_reg.rb;
            end
            I_MRMOVQ: begin
                d_srcB = fd_reg.rb;
                d_dstM = fd_reg.ra;
            end
            I_OPQ: begin
                d_srcA = fd_reg.ra;
                d_srcB = fd_reg.rb;
                d_dstE = fd_reg.rb;
            end
            I_CALL: begin
                d_srcB = RRSP;
                d_dstE = RRSP;
            end
            I_RET: begin
                d_srcA = RRSP;
                d_srcB = RRSP;
                d_dstE = RRSP;
            end
            I_PUSHQ: begin
                d_srcA = fd_reg.ra;
                d_srcB = RRSP;
                d_dstE = RRSP;
            end
            I_POPQ: begin
                d_srcA = RRSP;
                d_srcB = RRSP;
                d_dstE = RRSP;
                d_dstM = fd_reg.ra;
            end
            default: ;
        endcase
    end

    reg_file u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .src_a (d_srcA),
        .src_b (d_srcB),
        .dst_e (W_dstE),
        .dst_m (W_dstM),
        .val_e (W_valE),
        .val_m (W_valM),
        .val_a (rf_val_a),
        .val_b (rf_val_b)
    );

    // CALL and jumps carry the return/fall-through PC in valA instead of a register
    always_comb begin
        d_valA = rf_val_a;
        if (fd_reg.icode == I_CALL || fd_reg.icode == I_JXX)
            d_valA = fd_reg.valp;
    end

    assign d_valB  = rf_val_b;
    assign d_icode = fd_reg.icode;
    assign d_ifun  = fd_reg.ifun;
    assign d_valC  = fd_reg.valc;
    assign d_stat  = fd_reg.stat;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        f_instr_valid, f_imem_error;
    logic        D_stall, D_bubble;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  d_icode, d_ifun;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [2:0]  d_stat;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural model state
    logic [63:0] m_regs [15];
    logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
    logic [63:0] m_valc, m_valp;
    logic [2:0]  m_stat;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP),
        .f_instr_valid(f_instr_valid), .f_imem_error(f_imem_error),
        .D_stall(D_stall), .D_bubble(D_bubble),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
        .d_valA(d_valA), .d_valB(d_valB),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_stat(d_stat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] exp_srca();
        if (m_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return m_ra;
        if (m_icode inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_srcb();
        if (m_icode inside {4'h4, 4'h5, 4'h6}) return m_rb;
        if (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dste();
        if (m_icode inside {4'h2, 4'h3, 4'h6}) return m_rb;
        if (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dstm();
        if (m_icode inside {4'h5, 4'hB}) return m_ra;
        return 4'hF;
    endfunction

    // Register value as seen this cycle, including writes in flight
    function automatic logic [63:0] exp_read(input logic [3:0] r);
        if (r == 4'hF) return 64'd0;
        if (W_dstM == r) return W_valM;
        if (W_dstE == r) return W_valE;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
        m_icode = 4'h1; m_ifun = 4'h0; m_ra = 4'hF; m_rb = 4'hF;
        m_valc = 64'd0; m_valp = 64'd0; m_stat = 3'd1;
    endtask

    task automatic model_clock();
        if (rst) begin
            model_reset();
            return;
        end
        if (W_dstE != 4'hF) m_regs[W_dstE] = W_valE;
        if (W_dstM != 4'hF) m_regs[W_dstM] = W_valM;
        if (D_stall) begin
            // contents held
        end else if (D_bubble) begin
            m_icode = 4'h1; m_ifun = 4'h0; m_ra = 4'hF; m_rb = 4'hF;
            m_valc = 64'd0; m_valp = 64'd0; m_stat = 3'd1;
        end else begin
            m_icode = f_icode; m_ifun = f_ifun; m_ra = f_rA; m_rb = f_rB;
            m_valc = f_valC; m_valp = f_valP;
            m_stat = f_imem_error ? 3'd3 : (!f_instr_valid ? 3'd4 :
                     (f_icode == 4'h0 ? 3'd2 : 3'd1));
        end
    endtask

    task automatic compare_model();
        chk("icode", d_icode, m_icode);
        chk("ifun",  d_ifun,  m_ifun);
        chk("valC",  d_valC,  m_valc);
        chk("stat",  d_stat,  m_stat);
        chk("srcA",  d_srcA,  exp_srca());
        chk("srcB",  d_srcB,  exp_srcb());
        chk("dstE",  d_dstE,  exp_dste());
        chk("dstM",  d_dstM,  exp_dstm());
        chk("valA",  d_valA,  (m_icode inside {4'h7, 4'h8}) ? m_valp : exp_read(exp_srca()));
        chk("valB",  d_valB,  exp_read(exp_srcb()));
    endtask

    // One transaction: check mid-cycle, advance model, cross the edge
    task automatic tick();
        @(negedge clk);
        compare_model();
        $display("txn %0d rst=%0b stall=%0b bub=%0b f_icode=%h Wd=%h/%h d_icode=%h srcA=%h srcB=%h valA=%h valB=%h stat=%0d",
                 cyc, rst, D_stall, D_bubble, f_icode, W_dstE, W_dstM,
                 d_icode, d_srcA, d_srcB, d_valA, d_valB, d_stat);
        model_clock();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        rst = 0; D_stall = 0; D_bubble = 0;
        f_icode = 4'h1; f_ifun = 0; f_rA = 4'hF; f_rB = 4'hF;
        f_valC = 0; f_valP = 0; f_instr_valid = 1; f_imem_error = 0;
        W_dstE = 4'hF; W_dstM = 4'hF; W_valE = 0; W_valM = 0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] valp);
        f_icode = ic; f_rA = ra; f_rB = rb; f_valP = valp;
    endtask

    task automatic rand_inputs();
        rst           = ($urandom_range(0, 59) == 0);
        D_stall       = ($urandom_range(0, 5) == 0);
        D_bubble      = ($urandom_range(0, 5) == 0);
        f_icode       = 4'($urandom_range(0, 15));
        f_ifun        = 4'($urandom_range(0, 15));
        f_rA          = 4'($urandom_range(0, 15));
        f_rB          = 4'($urandom_range(0, 15));
        f_valC        = {$urandom, $urandom};
        f_valP        = {$urandom, $urandom};
        f_instr_valid = ($urandom_range(0, 9) != 0);
        f_imem_error  = ($urandom_range(0, 19) == 0);
        W_dstE        = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        W_dstM        = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        W_valE        = {$urandom, $urandom};
        W_valM        = {$urandom, $urandom};
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 0;
        #1;

        // Reset state
        chk("rst_icode", d_icode, 64'h1);
        chk("rst_ifun",  d_ifun,  64'h0);
        chk("rst_valC",  d_valC,  64'h0);
        chk("rst_srcA",  d_srcA,  64'hF);
        chk("rst_srcB",  d_srcB,  64'hF);
        chk("rst_dstE",  d_dstE,  64'hF);
        chk("rst_dstM",  d_dstM,  64'hF);
        chk("rst_valA",  d_valA,  64'h0);
        chk("rst_valB",  d_valB,  64'h0);
        chk("rst_stat",  d_stat,  64'h1);
        tick();

        // Write r3 while an OPQ reading r3 is in decode: bypass, then array
        fetch(4'h6, 4'h3, 4'h3, 64'h0);
        tick();
        W_dstE = 4'h3; W_valE = 64'h55;
        #1;
        chk("byp_valA", d_valA, 64'h55);
        chk("byp_valB", d_valB, 64'h55);
        tick();
        W_dstE = 4'hF;
        #1;
        chk("arr_valA", d_valA, 64'h55);
        chk("arr_valB", d_valB, 64'h55);
        tick();

        // POPQ with both write ports on rsp: M data wins
        fetch(4'hB, 4'h4, 4'hF, 64'h0);
        W_dstE = 4'h4; W_dstM = 4'h4; W_valE = 64'h10; W_valM = 64'h99;
        tick();
        W_dstE = 4'hF; W_dstM = 4'hF;
        fetch(4'h1, 4'hF, 4'hF, 64'h0);
        #1;
        chk("pop_rsp",  d_valA, 64'h99);
        chk("pop_srcA", d_srcA, 64'h4);
        chk("pop_dstM", d_dstM, 64'h4);
        chk("pop_dstE", d_dstE, 64'h4);
        tick();

        // CALL carries valP in valA
        fetch(4'h8, 4'hF, 4'hF, 64'h2A);
        tick();
        chk("call_valA", d_valA, 64'h2A);
        chk("call_srcB", d_srcB, 64'h4);
        chk("call_dstE", d_dstE, 64'h4);
        chk("call_srcA", d_srcA, 64'hF);

        // Stall holds for three cycles while fetch changes
        fetch(4'h6, 4'h1, 4'h2, 64'h0);
        f_ifun = 4'h3; f_valC = 64'h77;
        tick();
        for (int i = 0; i < 3; i++) begin
            D_stall = 1;
            fetch(4'($urandom_range(2, 11)), 4'($urandom_range(0, 14)), 4'h5, 64'h1234);
            f_ifun = 4'h0; f_valC = 64'hABCD;
            tick();
            chk("stall_icode", d_icode, 64'h6);
            chk("stall_ifun",  d_ifun,  64'h3);
            chk("stall_valC",  d_valC,  64'h77);
        end
        D_stall = 1; D_bubble = 1;
        tick();
        chk("stallbub_icode", d_icode, 64'h6);
        D_stall = 0; D_bubble = 1;
        tick();
        chk("bub_icode", d_icode, 64'h1);
        chk("bub_srcA",  d_srcA,  64'hF);
        chk("bub_valC",  d_valC,  64'h0);

        // Reset during a stall still clears the register
        D_bubble = 0; D_stall = 0;
        fetch(4'h2, 4'h1, 4'h2, 64'h0);
        tick();
        D_stall = 1; rst = 1;
        tick();
        chk("rststall_icode", d_icode, 64'h1);
        rst = 0; D_stall = 0;

        // Fetch status encoding
        f_imem_error = 1;
        tick();
        chk("stat_adr", d_stat, 64'h3);
        f_imem_error = 0; f_instr_valid = 0;
        tick();
        chk("stat_ins", d_stat, 64'h4);
        f_instr_valid = 1; f_icode = 4'h0;
        tick();
        chk("stat_hlt", d_stat, 64'h2);

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
